// File: rtl/biu_responder.sv
// Operand-service bus interface responder: 8 x 16-bit register file served over a
// shared tristate bus with an IDLE -> ACCESS -> DONE handshake.
module biu_responder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs_biu,
  input  logic [1:0]  sel,
  input  logic [1:0]  op_sel,
  input  logic [31:0] ir,
  inout  logic [15:0] bus,
  output logic        ready_biu,
  output logic        err,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {OP_RD_A = 2'b00, OP_RD_B = 2'b01,
                            OP_WR   = 2'b10, OP_RSVD = 2'b11} op_t;

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [2:0]  rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [15:0] data_q, data_d;
  logic        err_q, err_d;
  logic [15:0] regfile_q [8];
  logic [15:0] regfile_d [8];

  logic req, start, latch, bus_oe;
  logic unused_ir;

  // A floating (Z) request line must count as "no request".
  assign req       = (cs_biu === 1'b1);
  assign start     = req && (sel == 2'b10);
  assign unused_ir = ^{ir[31:30], ir[20:0]};

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    data_d    = data_q;
    err_d     = 1'b0;
    regfile_d = regfile_q;
    latch     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCESS;
          latch   = 1'b1;
        end
      end
      ACCESS: begin
        state_d = DONE;
        case (op_q)
          OP_RD_A: data_d = regfile_q[rs1_q];
          OP_RD_B: data_d = regfile_q[rs2_q];
          OP_WR:   regfile_d[rd_q] = bus;
          default: err_d = 1'b1;
        endcase
      end
      DONE: begin
        // A held request with an unchanged op is idempotent: no re-read, no re-write.
        if (!req) begin
          state_d = IDLE;
        end else if ((op_sel != op_q) && (sel == 2'b10)) begin
          state_d = ACCESS;
          latch   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (latch) begin
      op_d  = op_t'(op_sel);
      rd_d  = ir[29:27];
      rs1_d = ir[26:24];
      rs2_d = ir[23:21];
    end

    regfile_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_RD_A;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
        regfile_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      data_q    <= data_d;
      err_q     <= err_d;
      regfile_q <= regfile_d;
    end
  end

  assign bus_oe    = (state_q == DONE) && req && ((op_q == OP_RD_A) || (op_q == OP_RD_B));
  assign bus       = bus_oe ? data_q : 'z;
  assign ready_biu = (state_q == DONE);
  assign err       = err_q;
  assign dbg_data  = regfile_q[dbg_addr];

endmodule
